// File: rtl/key_expansion_pkg.sv
// Shared definitions for the S-AES key schedule: widths, default round
// constants, FSM states and the 4-bit S-box.
package key_expansion_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 8;

  localparam logic [WORD_W-1:0] RCON1_DEF = 8'h80;
  localparam logic [WORD_W-1:0] RCON2_DEF = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    R1   = 2'd1,
    R2   = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [NIB_W-1:0] sbox(input logic [NIB_W-1:0] n);
    logic [NIB_W-1:0] s;
    case (n)
      4'h0: s = 4'h9;
      4'h1: s = 4'h4;
      4'h2: s = 4'hA;
      4'h3: s = 4'hB;
      4'h4: s = 4'hD;
      4'h5: s = 4'h1;
      4'h6: s = 4'h8;
      4'h7: s = 4'h5;
      4'h8: s = 4'h6;
      4'h9: s = 4'h2;
      4'hA: s = 4'h0;
      4'hB: s = 4'h3;
      4'hC: s = 4'hC;
      4'hD: s = 4'hE;
      4'hE: s = 4'hF;
      default: s = 4'h7;
    endcase
    return s;
  endfunction

  function automatic logic [WORD_W-1:0] rot_nib(input logic [WORD_W-1:0] w);
    return {w[NIB_W-1:0], w[WORD_W-1:NIB_W]};
  endfunction

endpackage

// File: rtl/key_expansion_sub_nib.sv
// SubNib stage of g(): substitutes each nibble of an 8-bit word through the S-box.
module sub_nib
  import key_expansion_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  assign dout = {sbox(din[WORD_W-1:NIB_W]), sbox(din[NIB_W-1:0])};

endmodule

// File: rtl/key_expansion.sv
// Sequential S-AES key schedule: one g() round per clock through a single
// shared sub_nib datapath, K0..K2 presented with a valid/ready handshake.
module key_expansion
  import key_expansion_pkg::*;
#(
  parameter logic [WORD_W-1:0] RCON1 = RCON1_DEF,
  parameter logic [WORD_W-1:0] RCON2 = RCON2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] key_in,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [15:0] k0,
  output logic [15:0] k1,
  output logic [15:0] k2
);

  state_t state, state_nxt;

  logic [WORD_W-1:0] g_sel, g_in, g_out;
  logic [WORD_W-1:0] w2, w3, w4, w5;

  // k0/k1 double as the w0..w3 working registers for the following round
  assign g_sel = (state == R2) ? k1[WORD_W-1:0] : k0[WORD_W-1:0];
  assign g_in  = rot_nib(g_sel);

  sub_nib u_g (
    .din  (g_in),
    .dout (g_out)
  );

  assign w2 = k0[15:8] ^ RCON1 ^ g_out;
  assign w3 = w2 ^ k0[7:0];
  assign w4 = k1[15:8] ^ RCON2 ^ g_out;
  assign w5 = w4 ^ k1[7:0];

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = R1;
      R1:      state_nxt = R2;
      R2:      state_nxt = DONE;
      DONE:    if (key_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
    end else begin
      state     <= state_nxt;
      key_valid <= (state_nxt == DONE);
      case (state)
        IDLE:    if (in_valid) k0 <= key_in;
        R1:      k1 <= {w2, w3};
        R2:      k2 <= {w4, w5};
        default: ;
      endcase
    end
  end

endmodule
